// File: rtl/lcd_char_writer.sv
// HD44780-style 8-bit character LCD writer: power-up init, rs/en/data timing,
// cursor column tracking with re-home, one-deep holding buffer with overrun pulse.
module lcd_char_writer #(
  parameter int unsigned POWERUP_CYCLES    = 2000000,
  parameter int unsigned SETUP_CYCLES      = 4,
  parameter int unsigned EN_PULSE_CYCLES   = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 5000,
  parameter int unsigned CLEAR_WAIT_CYCLES = 200000,
  parameter int unsigned LINE_LEN          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       en,
  output logic       rs,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned MAX_AB = (POWERUP_CYCLES > CLEAR_WAIT_CYCLES) ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int unsigned MAX_CD = (CMD_WAIT_CYCLES > EN_PULSE_CYCLES) ? CMD_WAIT_CYCLES : EN_PULSE_CYCLES;
  localparam int unsigned MAX_EF = (MAX_CD > SETUP_CYCLES) ? MAX_CD : SETUP_CYCLES;
  localparam int unsigned MAXC   = (MAX_AB > MAX_EF) ? MAX_AB : MAX_EF;
  localparam int unsigned CW     = $clog2(MAXC + 1);
  localparam int unsigned COLW   = $clog2(LINE_LEN + 1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    SETUP,
    PULSE,
    WAIT,
    IDLE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, busy_q, ovf_q, ovf_d;
  logic [COLW-1:0] col_q, col_d;
  logic            init_q, init_d;
  logic [1:0]      idx_q, idx_d;
  logic            pend_v_q, pend_v_d;
  logic [7:0]      pend_b_q, pend_b_d;
  logic            def_v_q, def_v_d;
  logic [7:0]      def_b_q, def_b_d;
  logic            launch;
  logic [7:0]      launch_byte;
  logic [CW-1:0]   wait_last;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign wait_last = (!rs_q && data_q == 8'h01) ? CW'(CLEAR_WAIT_CYCLES - 1)
                                                : CW'(CMD_WAIT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CW'(1);
    data_d      = data_q;
    rs_d        = rs_q;
    col_d       = col_q;
    init_d      = init_q;
    idx_d       = idx_q;
    pend_v_d    = pend_v_q;
    pend_b_d    = pend_b_q;
    def_v_d     = def_v_q;
    def_b_d     = def_b_q;
    ovf_d       = 1'b0;
    launch      = 1'b0;
    launch_byte = '0;

    if (wr_en && state_q != IDLE) begin
      if (!pend_v_q) begin
        pend_v_d = 1'b1;
        pend_b_d = data_in;
      end else begin
        ovf_d = 1'b1;
      end
    end

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d = SETUP;
          cnt_d   = '0;
          data_d  = init_cmd(2'd0);
          rs_d    = 1'b0;
          idx_d   = 2'd0;
        end
      end
      SETUP: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          state_d = PULSE;
          cnt_d   = '0;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(EN_PULSE_CYCLES - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (init_q && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            data_d  = init_cmd(idx_q + 2'd1);
            rs_d    = 1'b0;
            state_d = SETUP;
          end else begin
            if (init_q) begin
              init_d = 1'b0;
              col_d  = '0;
            end else if (rs_q) begin
              col_d = col_q + COLW'(1);
            end
            // A character held back by a re-home goes ahead of the holding buffer.
            if (def_v_q) begin
              launch      = 1'b1;
              launch_byte = def_b_q;
              def_v_d     = 1'b0;
            end else if (pend_v_d) begin
              launch      = 1'b1;
              launch_byte = pend_b_d;
              pend_v_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (wr_en) begin
          launch      = 1'b1;
          launch_byte = data_in;
        end
      end
      default: state_d = PWR_WAIT;
    endcase

    if (launch) begin
      state_d = SETUP;
      cnt_d   = '0;
      if (col_d == COLW'(LINE_LEN)) begin
        data_d  = 8'h80;
        rs_d    = 1'b0;
        col_d   = '0;
        def_v_d = 1'b1;
        def_b_d = launch_byte;
      end else begin
        data_d = launch_byte;
        rs_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PWR_WAIT;
      cnt_q    <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b1;
      ovf_q    <= 1'b0;
      col_q    <= '0;
      init_q   <= 1'b1;
      idx_q    <= '0;
      pend_v_q <= 1'b0;
      pend_b_q <= '0;
      def_v_q  <= 1'b0;
      def_b_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= (state_d == PULSE);
      busy_q   <= (state_d != IDLE);
      ovf_q    <= ovf_d;
      col_q    <= col_d;
      init_q   <= init_d;
      idx_q    <= idx_d;
      pend_v_q <= pend_v_d;
      pend_b_q <= pend_b_d;
      def_v_q  <= def_v_d;
      def_b_q  <= def_b_d;
    end
  end

  assign data_out = data_q;
  assign rs       = rs_q;
  assign en       = en_q;
  assign busy     = busy_q;
  assign overrun  = ovf_q;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timing; a negedge monitor
// logs every en pulse (data, rs, start cycle, width) for the main sequence to check.
module tb_lcd_char_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       en, rs, busy, overrun;

  lcd_char_writer #(
    .POWERUP_CYCLES   (20),
    .SETUP_CYCLES     (2),
    .EN_PULSE_CYCLES  (3),
    .CMD_WAIT_CYCLES  (5),
    .CLEAR_WAIT_CYCLES(10),
    .LINE_LEN         (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .data_in (data_in),
    .data_out(data_out),
    .en      (en),
    .rs      (rs),
    .busy    (busy),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         failures = 0;
  int         rel = 0;
  int         log_n = 0;
  logic [7:0] log_d[64];
  logic       log_rs[64];
  int         log_t[64];
  int         log_w[64];
  int         ovf_cnt = 0;
  logic       en_prev = 1'b0;

  always @(negedge clk) begin
    if (en && !en_prev && log_n < 64) begin
      log_d[log_n]  <= data_out;
      log_rs[log_n] <= rs;
      log_t[log_n]  <= cyc - rel;
      log_w[log_n]  <= 1;
      log_n         <= log_n + 1;
    end else if (en && en_prev && log_n > 0) begin
      log_w[log_n-1] <= log_w[log_n-1] + 1;
    end
    if (overrun) ovf_cnt <= ovf_cnt + 1;
    en_prev <= en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic release_reset();
    reset = 1'b0;
    rel   = cyc;
  endtask

  // Returns the cycle number at which busy is first seen low, or -1 on timeout.
  task automatic wait_idle(input int max, output int t);
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic chk_pulse(input string tag, input int idx, input logic [7:0] d, input logic r);
    check(tag, {15'd0, log_d[idx], log_rs[idx], 8'(log_w[idx])}, {15'd0, d, r, 8'd3});
  endtask

  task automatic chk_init(input string tag, input int base);
    logic [7:0] cmds[4];
    cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
    for (int i = 0; i < 4; i++) chk_pulse(tag, base + i, cmds[i], 1'b0);
  endtask

  initial begin
    int         t, t0, base, obase;
    logic [7:0] howdy[5];
    logic       seen;
    howdy = '{8'h48, 8'h4F, 8'h57, 8'h44, 8'h59};

    step(3);
    check("reset_vals", {23'd0, data_out, en, rs, busy, overrun}, {23'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});

    // Power-up init
    base = log_n; obase = ovf_cnt;
    release_reset();
    wait_idle(200, t);
    check("init_busy_fall", t - rel, 65);
    check("init_pulse_cnt", log_n - base, 4);
    chk_init("init_pulse", base);
    check("init_first_en", log_t[base], 22);
    check("init_no_ovf", ovf_cnt - obase, 0);

    // Single character
    step(3);
    base = log_n;
    wr(8'h48);
    t0 = cyc;
    check("char_setup", {20'd0, rs, data_out, en, busy, 1'b0}, {20'd0, 1'b1, 8'h48, 1'b0, 1'b1, 1'b0});
    step(1);
    check("char_en_low_n2", en, 1'b0);
    step(1);
    check("char_en_high_n3", en, 1'b1);
    wait_idle(50, t);
    check("char_busy_fall", t - t0, 10);
    chk_pulse("char_pulse", base, 8'h48, 1'b1);
    check("char_en_start", log_t[base], t0 - rel + 2);

    // Holding buffer and overrun
    step(3);
    base = log_n; obase = ovf_cnt;
    wr(8'h41);
    t0 = cyc;
    step(1);
    wr(8'h42);
    wr(8'h43);
    check("ovf_pulse", overrun, 1'b1);
    step(1);
    check("ovf_one_cycle", overrun, 1'b0);
    wait_idle(80, t);
    check("pend_busy_fall", t - t0, 20);
    check("pend_pulse_cnt", log_n - base, 2);
    chk_pulse("pend_a", base, 8'h41, 1'b1);
    chk_pulse("pend_b", base + 1, 8'h42, 1'b1);
    check("pend_b_start", log_t[base + 1] - log_t[base], 10);
    check("ovf_cnt", ovf_cnt - obase, 1);

    // Column wrap from a fresh init
    reset = 1'b1;
    step(2);
    base = log_n;
    release_reset();
    wait_idle(200, t);
    check("reinit_busy_fall", t - rel, 65);
    base = log_n;
    for (int i = 0; i < 5; i++) begin
      wr(howdy[i]);
      step(19);
    end
    wait_idle(80, t);
    check("wrap_busy_seen", {31'd0, t >= 0}, 32'd1);
    check("wrap_pulse_cnt", log_n - base, 6);
    for (int i = 0; i < 4; i++) chk_pulse("wrap_char", base + i, howdy[i], 1'b1);
    chk_pulse("wrap_home", base + 4, 8'h80, 1'b0);
    chk_pulse("wrap_y", base + 5, 8'h59, 1'b1);

    // Write during init
    reset = 1'b1;
    step(2);
    base = log_n;
    release_reset();
    step(5);
    wr(8'h5A);
    wait_idle(200, t);
    check("initwr_busy_fall", t - rel, 75);
    check("initwr_pulse_cnt", log_n - base, 5);
    chk_init("initwr_init", base);
    chk_pulse("initwr_char", base + 4, 8'h5A, 1'b1);

    // Reset mid-pulse with a byte pending
    step(3);
    wr(8'h55);
    wr(8'h66);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("midrst_en_seen", seen, 1'b1);
    reset = 1'b1;
    step(1);
    check("midrst_vals", {23'd0, data_out, en, rs, busy, overrun}, {23'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    base = log_n;
    release_reset();
    wait_idle(200, t);
    check("midrst_busy_fall", t - rel, 65);
    check("midrst_pulse_cnt", log_n - base, 4);
    chk_init("midrst_init", base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
